sprite_motion_ctrl: RTL and testbench

Upstream neighbour of the sprite renderer. Owns the sprite's position and velocity and advances them once per frame on the rising edge of vertical sync. Runs entirely in the pixel-clock domain; no logic is clocked by vsync. Presents an atomically updated (x, y) pair to the sprite stage, plus per-frame bounce/tick status.

---
 rtl/sprite_pkg.sv | 19 +
 rtl/axis_bounce.sv | 41 ++++
 rtl/sprite_motion_ctrl.sv | 176 +++++++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite motion slice.
// Optional build macro used by sprite_motion_ctrl: SPRITE_MOTION_STEP_EN.
package sprite_pkg;

  // Default signed width of coordinates and velocities.
  localparam int SPR_COORD_W = 16;

  // Screen size in sprite-grid units (exclusive upper bounds).
  localparam int SPR_GRID_W = 200;
  localparam int SPR_GRID_H = 150;

  // Per-frame motion sequencer.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2
  } motion_state_t;

endpackage

// File: rtl/axis_bounce.sv
// Combinational single-axis step: next = coord + vel, clamped to
// [0, MAX-1] with the velocity reflected whenever a wall is crossed.
module axis_bounce #(
  parameter int COORD_W = 16,
  parameter int MAX     = 200
) (
  input  logic signed [COORD_W-1:0] coord,
  input  logic signed [COORD_W-1:0] vel,
  output logic signed [COORD_W-1:0] new_coord,
  output logic signed [COORD_W-1:0] new_vel,
  output logic                      bounce
);

  localparam logic signed [COORD_W:0]   MAX_S = (COORD_W+1)'(MAX);
  localparam logic signed [COORD_W-1:0] TOP   = COORD_W'(MAX - 1);

  // One extra bit so coord + vel can never wrap.
  logic signed [COORD_W:0] next;

  // Sum, then clamp and reflect against the low and high walls.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    next      = {coord[COORD_W-1], coord} + {vel[COORD_W-1], vel};
    new_coord = next[COORD_W-1:0];
    new_vel   = vel;
    bounce    = 1'b0;
    // A stationary axis never bounces, even if it sits out of range.
    if (vel != '0) begin
      if (next >= MAX_S) begin
        new_coord = TOP;
        new_vel   = -vel;
        bounce    = 1'b1;
      end else if (next[COORD_W]) begin
        new_coord = '0;
        new_vel   = -vel;
        bounce    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Sprite position/velocity owner. Advances motion once per rising vsync
// edge (detected in the pixel-clock domain) and publishes the new (x, y)
// pair, velocities and bounce flags in a single commit cycle.
// Optional build macro: SPRITE_MOTION_STEP_EN adds i_step single-frame
// stepping while i_enable is low.
module sprite_motion_ctrl
  import sprite_pkg::*;
#(
  parameter int COORD_W = SPR_COORD_W,
  parameter int X_MAX   = SPR_GRID_W,
  parameter int Y_MAX   = SPR_GRID_H,
  parameter int INIT_X  = 0,
  parameter int INIT_Y  = 0,
  parameter int INIT_VX = 3,
  parameter int INIT_VY = 2
) (
  input  logic                      i_pix_clk,
  input  logic                      i_reset,
  input  logic                      i_vert_sync,
  input  logic                      i_enable,
  input  logic                      i_vel_load,
  input  logic signed [COORD_W-1:0] i_vel_x,
  input  logic signed [COORD_W-1:0] i_vel_y,
`ifdef SPRITE_MOTION_STEP_EN
  input  logic                      i_step,
`endif
  output logic signed [COORD_W-1:0] o_x_coord,
  output logic signed [COORD_W-1:0] o_y_coord,
  output logic signed [COORD_W-1:0] o_vel_x,
  output logic signed [COORD_W-1:0] o_vel_y,
  output logic                      o_frame_tick,
  output logic                      o_bounce_x,
  output logic                      o_bounce_y,
  output logic                      o_busy
);

  motion_state_t state, state_nxt;

  logic                      vs_q;
  logic                      vs_edge;
  logic                      go;
  logic signed [COORD_W-1:0] x_q, y_q, vx_q, vy_q;
  logic                      bx_q, by_q;
  logic                      pend_valid;
  logic signed [COORD_W-1:0] pend_vx, pend_vy;
  logic signed [COORD_W-1:0] nx, ny, nvx, nvy;
  logic                      bx_nxt, by_nxt;

  assign vs_edge = i_vert_sync & ~vs_q;

`ifdef SPRITE_MOTION_STEP_EN
  logic step_armed;

  assign go = vs_edge & (i_enable | step_armed);

  // One-shot: armed by i_step while frozen, spent by the next frame taken.
  always_ff @(posedge i_pix_clk or posedge i_reset) begin
    if (i_reset) begin
      step_armed <= 1'b0;
    end else if (i_enable) begin
      step_armed <= 1'b0;
    end else if (state == IDLE && go) begin
      step_armed <= 1'b0;
    end else if (i_step) begin
      step_armed <= 1'b1;
    end
  end
`else
  assign go = vs_edge & i_enable;
`endif

  // Vsync history; reset high so a vsync already high at release is no edge.
  always_ff @(posedge i_pix_clk or posedge i_reset) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (i_reset) vs_q <= 1'b1;
    else         vs_q <= i_vert_sync;
  end

  // FSM state register.
  always_ff @(posedge i_pix_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // FSM next state; edges seen while busy are dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = CALC;
      CALC:    state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    o_busy       = (state != IDLE);
    o_frame_tick = (state == COMMIT);
  end

  axis_bounce #(.COORD_W(COORD_W), .MAX(X_MAX)) u_axis_x (
    .coord     (x_q),
    .vel       (vx_q),
    .new_coord (nx),
    .new_vel   (nvx),
    .bounce    (bx_nxt)
  );

  axis_bounce #(.COORD_W(COORD_W), .MAX(Y_MAX)) u_axis_y (
    .coord     (y_q),
    .vel       (vy_q),
    .new_coord (ny),
    .new_vel   (nvy),
    .bounce    (by_nxt)
  );

  // Motion registers: idle loads, all-at-once commit, late-load apply.
  always_ff @(posedge i_pix_clk or posedge i_reset) begin
    if (i_reset) begin
      x_q        <= COORD_W'(INIT_X);
      y_q        <= COORD_W'(INIT_Y);
      vx_q       <= COORD_W'(INIT_VX);
      vy_q       <= COORD_W'(INIT_VY);
      bx_q       <= 1'b0;
      by_q       <= 1'b0;
      pend_valid <= 1'b0;
      pend_vx    <= '0;
      pend_vy    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A load coinciding with the edge lands before CALC reads it.
          if (i_vel_load) begin
            vx_q <= i_vel_x;
            vy_q <= i_vel_y;
          end
        end
        CALC: begin
          // Coordinates, velocities and flags become visible together.
          x_q  <= nx;
          y_q  <= ny;
          vx_q <= nvx;
          vy_q <= nvy;
          bx_q <= bx_nxt;
          by_q <= by_nxt;
          if (i_vel_load) begin
            pend_valid <= 1'b1;
            pend_vx    <= i_vel_x;
            pend_vy    <= i_vel_y;
          end
        end
        COMMIT: begin
          // A load held from CALC (or arriving now) beats the reflection.
          if (i_vel_load) begin
            vx_q <= i_vel_x;
            vy_q <= i_vel_y;
          end else if (pend_valid) begin
            vx_q <= pend_vx;
            vy_q <= pend_vy;
          end
          pend_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_x_coord  = x_q;
  assign o_y_coord  = y_q;
  assign o_vel_x    = vx_q;
  assign o_vel_y    = vy_q;
  assign o_bounce_x = bx_q;
  assign o_bounce_y = by_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl: directed wall/load/reset cases
// followed by randomized frames against a plain-arithmetic motion model.
module tb_sprite_motion_ctrl;

  localparam int W     = 16;
  localparam int X_MAX = 200;
  localparam int Y_MAX = 150;

  logic          i_pix_clk = 1'b0;
  logic          i_reset   = 1'b1;
  logic          i_vert_sync = 1'b0;
  logic          i_enable  = 1'b0;
  logic          i_vel_load = 1'b0;
  logic [W-1:0]  i_vel_x   = '0;
  logic [W-1:0]  i_vel_y   = '0;
`ifdef SPRITE_MOTION_STEP_EN
  logic          i_step    = 1'b0;
`endif
  logic [W-1:0]  o_x_coord, o_y_coord, o_vel_x, o_vel_y;
  logic          o_frame_tick, o_bounce_x, o_bounce_y, o_busy;

  sprite_motion_ctrl #(
    .COORD_W (W), .X_MAX (X_MAX), .Y_MAX (Y_MAX),
    .INIT_X (0), .INIT_Y (0), .INIT_VX (3), .INIT_VY (2)
  ) dut (
    .i_pix_clk    (i_pix_clk),
    .i_reset      (i_reset),
    .i_vert_sync  (i_vert_sync),
    .i_enable     (i_enable),
    .i_vel_load   (i_vel_load),
    .i_vel_x      (i_vel_x),
    .i_vel_y      (i_vel_y),
`ifdef SPRITE_MOTION_STEP_EN
    .i_step       (i_step),
`endif
    .o_x_coord    (o_x_coord),
    .o_y_coord    (o_y_coord),
    .o_vel_x      (o_vel_x),
    .o_vel_y      (o_vel_y),
    .o_frame_tick (o_frame_tick),
    .o_bounce_x   (o_bounce_x),
    .o_bounce_y   (o_bounce_y),
    .o_busy       (o_busy)
  );

  always #5 i_pix_clk = ~i_pix_clk;

  int cyc = 0;
  always @(posedge i_pix_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Expected commit, queued when the qualifying edge is driven.
  typedef struct {
    int cyc;
    int x, y, vx, vy;
    bit bx, by;
    bit chk_vel;
  } exp_t;

  exp_t sb[$];

  // Reference model state.
  int m_x = 0, m_y = 0, m_vx = 3, m_vy = 2;
  bit m_bx = 0, m_by = 0;
`ifdef SPRITE_MOTION_STEP_EN
  bit m_armed = 0;
`endif

  function automatic void axis(input int c, input int v, input int max,
                               output int nc, output int nv, output bit b);
    int n;
    n  = c + v;
    nc = n;
    nv = v;
    b  = 1'b0;
    if (v != 0 && n >= max) begin
      nc = max - 1; nv = -v; b = 1'b1;
    end else if (v != 0 && n < 0) begin
      nc = 0; nv = -v; b = 1'b1;
    end
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_vx = 3; m_vy = 2; m_bx = 0; m_by = 0;
`ifdef SPRITE_MOTION_STEP_EN
    m_armed = 0;
`endif
  endtask

  // Monitor: every tick must match the oldest queued commit.
  always @(negedge i_pix_clk) begin
    if (!i_reset && o_frame_tick) begin
      if (sb.size() == 0) begin
        check("unexpected_tick", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("tick_latency", cyc, e.cyc + 2);
        check("tick_x", $signed(o_x_coord), e.x);
        check("tick_y", $signed(o_y_coord), e.y);
        check("tick_bounce_x", o_bounce_x, e.bx);
        check("tick_bounce_y", o_bounce_y, e.by);
        if (e.chk_vel) begin
          check("tick_vx", $signed(o_vel_x), e.vx);
          check("tick_vy", $signed(o_vel_y), e.vy);
        end
      end
    end
  end

  task automatic check_state(input string tag);
    check({tag, "_x"},  $signed(o_x_coord), m_x);
    check({tag, "_y"},  $signed(o_y_coord), m_y);
    check({tag, "_vx"}, $signed(o_vel_x), m_vx);
    check({tag, "_vy"}, $signed(o_vel_y), m_vy);
    check({tag, "_bx"}, o_bounce_x, m_bx);
    check({tag, "_by"}, o_bounce_y, m_by);
  endtask

  // One vsync pulse. Optional load with the edge, optional load during CALC.
  // Entered and left #1 after a rising clock edge with vsync low.
  task automatic frame(input bit en, input bit ld, input int lvx, input int lvy,
                       input bit bld, input int bvx, input int bvy);
    bit   qual;
    exp_t e;
    i_enable    = en;
    i_vert_sync = 1'b1;
    i_vel_load  = ld;
    i_vel_x     = W'(lvx);
    i_vel_y     = W'(lvy);
    if (ld) begin m_vx = lvx; m_vy = lvy; end
    qual = en;
`ifdef SPRITE_MOTION_STEP_EN
    if (!en && m_armed) begin qual = 1'b1; m_armed = 1'b0; end
`endif
    if (qual) begin
      int nx, nvx, ny, nvy;
      bit bx, by;
      axis(m_x, m_vx, X_MAX, nx, nvx, bx);
      axis(m_y, m_vy, Y_MAX, ny, nvy, by);
      m_x = nx; m_vx = nvx; m_bx = bx;
      m_y = ny; m_vy = nvy; m_by = by;
      e.cyc = cyc; e.x = m_x; e.y = m_y; e.vx = m_vx; e.vy = m_vy;
      e.bx = m_bx; e.by = m_by; e.chk_vel = !bld;
      sb.push_back(e);
    end
    @(posedge i_pix_clk); #1;
    i_vel_load = bld;
    i_vel_x    = W'(bvx);
    i_vel_y    = W'(bvy);
    if (qual) check("busy_in_calc", o_busy, 1);
    if (bld) begin m_vx = bvx; m_vy = bvy; end
    @(posedge i_pix_clk); #1;
    i_vel_load = 1'b0;
    @(posedge i_pix_clk); #1;
    i_vert_sync = 1'b0;
    repeat (3) @(posedge i_pix_clk);
    #1;
    check_state("frame");
  endtask

  task automatic idle_load(input int vx, input int vy);
    i_vel_load = 1'b1;
    i_vel_x    = W'(vx);
    i_vel_y    = W'(vy);
    @(posedge i_pix_clk); #1;
    i_vel_load = 1'b0;
    m_vx = vx; m_vy = vy;
    check("idle_load_vx", $signed(o_vel_x), m_vx);
    check("idle_load_vy", $signed(o_vel_y), m_vy);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge i_pix_clk);
    #1;
    check("reset_tick", o_frame_tick, 0);
    check("reset_busy", o_busy, 0);
    check_state("reset");
    i_reset = 1'b0;
    repeat (2) @(posedge i_pix_clk);
    #1;

    // Free run from reset: (3,2), (6,4), (9,6).
    repeat (3) frame(1, 0, 0, 0, 0, 0, 0);

    // X high wall, then recovery.
    frame(1, 1, 189, 0, 0, 0, 0);   // x=198
    frame(1, 1, 3, 0, 0, 0, 0);     // x=199, vx=-3, bounce
    frame(1, 0, 0, 0, 0, 0, 0);     // x=196, no bounce

    // Y low wall, then a corner hitting both walls.
    frame(1, 1, 0, -5, 0, 0, 0);    // y=1
    frame(1, 1, 0, -2, 0, 0, 0);    // y=0, vy=+2, bounce
    frame(1, 1, 10, -3, 0, 0, 0);   // both bounce

    // Frozen frame.
    frame(0, 0, 0, 0, 0, 0, 0);

    // Load with the edge: (10,10) -> (15,9).
    frame(1, 1, -189, 10, 0, 0, 0);
    frame(1, 1, 5, -1, 0, 0, 0);

    // Load during CALC while x bounces; loaded velocity wins afterwards.
    frame(1, 1, 190, 0, 1, 7, 1);

    // Async reset during CALC.
    i_enable = 1'b1;
    i_vert_sync = 1'b1;
    @(posedge i_pix_clk); #1;
    check("rst_busy_in_calc", o_busy, 1);
    #2 i_reset = 1'b1;
    #1;
    check("rst_mid_x", $signed(o_x_coord), 0);
    check("rst_mid_y", $signed(o_y_coord), 0);
    check("rst_mid_vx", $signed(o_vel_x), 3);
    check("rst_mid_vy", $signed(o_vel_y), 2);
    check("rst_mid_tick", o_frame_tick, 0);
    check("rst_mid_busy", o_busy, 0);
    i_vert_sync = 1'b0;
    model_reset();
    @(posedge i_pix_clk); #1;
    @(posedge i_pix_clk); #1;
    i_reset = 1'b0;
    repeat (4) @(posedge i_pix_clk);
    #1;
    check_state("post_rst");

    // Vsync held high across reset release.
    i_reset = 1'b1;
    i_vert_sync = 1'b1;
    @(posedge i_pix_clk); #1;
    i_reset = 1'b0;
    repeat (5) @(posedge i_pix_clk);
    #1;
    check_state("vs_high_release");
    i_vert_sync = 1'b0;
    repeat (2) @(posedge i_pix_clk);
    #1;
    frame(1, 0, 0, 0, 0, 0, 0);     // (3,2)

`ifdef SPRITE_MOTION_STEP_EN
    // Single step while frozen: two edges, one update.
    i_enable = 1'b0;
    i_step   = 1'b1;
    @(posedge i_pix_clk); #1;
    i_step   = 1'b0;
    m_armed  = 1'b1;
    frame(0, 0, 0, 0, 0, 0, 0);
    frame(0, 0, 0, 0, 0, 0, 0);
`endif

    // Randomized frames.
    for (int i = 0; i < 60; i++) begin
      bit en, ld;
      int vx, vy;
      en = ($urandom_range(3) != 0);
      ld = ($urandom_range(2) == 0);
      vx = int'($urandom_range(120)) - 60;
      vy = int'($urandom_range(120)) - 60;
      if ($urandom_range(4) == 0) idle_load(int'($urandom_range(20)) - 10,
                                            int'($urandom_range(20)) - 10);
      frame(en, ld, vx, vy, 0, 0, 0);
    end

    // Let any outstanding commit drain, bounded.
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge i_pix_clk);
    check("scoreboard_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
